// File: rtl/diffout_arbiter_if.sv
// Bus bundle between the requesters and the differential output arbiter.
// The master side drives the requests and words; the slave side is the arbiter.
interface diffout_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       REQ;
   logic [NREQ*WIDTH-1:0] DIN;
   logic                  HIZ;
   logic [NREQ-1:0]       ACK;
   logic [NREQ-1:0]       GNT;
   logic                  TX_I;
   logic                  TX_T;
   logic                  BUSY;

   modport master (
      output REQ, DIN, HIZ,
      input  ACK, GNT, TX_I, TX_T, BUSY
   );

   modport slave (
      input  REQ, DIN, HIZ,
      output ACK, GNT, TX_I, TX_T, BUSY
   );
endinterface

// File: rtl/diffout_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one differential pair.
// Each frame is a start bit, WIDTH data bits LSB first, then GUARD hi-Z
// turnaround cycles. Every output is a register loaded from next-state logic.
module diffout_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int GUARD = 2
) (
   input logic              C,
   input logic              R,
   diffout_arbiter_if.slave bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int GW = 4;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] SHIFT = 2'd2;
   localparam logic [1:0] TURN  = 2'd3;

   localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);
   localparam logic [PW-1:0] PTR_LAST   = PW'(NREQ - 1);
   localparam logic [PW:0]   NREQ_W     = (PW + 1)'(NREQ);

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             tx_i_q, tx_i_d;
   logic             tx_t_q, tx_t_d;
   logic             busy_q;

   // Per-requester view of the packed data bus.
   logic [WIDTH-1:0] din_slice [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign din_slice[gi] = bus.DIN[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Requests rotated so that bit 0 is the requester the pointer names.
   logic [NREQ-1:0] req_rot;
   logic            found;
   logic [PW-1:0]   offset;
   logic [PW:0]     win_sum;
   logic [PW-1:0]   win;
   logic [NREQ-1:0] win_oh;

   assign req_rot = NREQ'({bus.REQ, bus.REQ} >> ptr_q);

   // Round-robin pick: lowest set bit of the rotated request vector.
   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_rot[k]) begin
            found  = 1'b1;
            offset = PW'(k);
         end
      end
   end

   assign win_sum = {1'b0, ptr_q} + {1'b0, offset};
   assign win     = PW'((win_sum >= NREQ_W) ? (win_sum - NREQ_W) : win_sum);
   assign win_oh  = NREQ'(1) << win;

   // Frame sequencing and next values of every registered output.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      bit_cnt_d   = bit_cnt_q;
      guard_cnt_d = guard_cnt_q;
      word_d      = word_q;
      gnt_d       = gnt_q;
      ack_d       = '0;
      tx_i_d      = 1'b0;
      tx_t_d      = 1'b1;
      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (!bus.HIZ && found) begin
               state_d = START;
               ptr_d   = (win == PTR_LAST) ? '0 : win + 1'b1;
               word_d  = din_slice[win];
               ack_d   = win_oh;
               gnt_d   = win_oh;
               tx_t_d  = 1'b0;
               tx_i_d  = 1'b1;
            end
         end
         START: begin
            if (bus.HIZ) begin
               state_d     = TURN;
               guard_cnt_d = '0;
            end else begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
               tx_t_d    = 1'b0;
               tx_i_d    = word_q[0];
               word_d    = word_q >> 1;
            end
         end
         SHIFT: begin
            if (bus.HIZ || bit_cnt_q == BIT_LAST) begin
               // Abort or normal end: both hand over to a full turnaround.
               state_d     = TURN;
               bit_cnt_d   = '0;
               guard_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               tx_t_d    = 1'b0;
               tx_i_d    = word_q[0];
               word_d    = word_q >> 1;
            end
         end
         default: begin
            // TURN: hold the grant until the last guard cycle has elapsed.
            if (guard_cnt_q == GUARD_LAST) begin
               state_d     = IDLE;
               guard_cnt_d = '0;
               gnt_d       = '0;
            end else begin
               guard_cnt_d = guard_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge C) begin
      if (R) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         bit_cnt_q   <= '0;
         guard_cnt_q <= '0;
         word_q      <= '0;
         gnt_q       <= '0;
         ack_q       <= '0;
         tx_i_q      <= 1'b0;
         tx_t_q      <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         bit_cnt_q   <= bit_cnt_d;
         guard_cnt_q <= guard_cnt_d;
         word_q      <= word_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         tx_i_q      <= tx_i_d;
         tx_t_q      <= tx_t_d;
         busy_q      <= (state_d != IDLE);
      end
   end

   assign bus.ACK  = ack_q;
   assign bus.GNT  = gnt_q;
   assign bus.TX_I = tx_i_q;
   assign bus.TX_T = tx_t_q;
   assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_diffout_arbiter.sv
// Randomized scoreboard bench for diffout_arbiter. The reference model
// describes each frame as a queue of expected line symbols built at grant
// time; a separate monitor pops expectations as the DUT presents outputs.
module tb_diffout_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int GUARD = 2;

   logic C = 1'b0;
   logic R;

   diffout_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   diffout_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .GUARD(GUARD)) dut (
      .C   (C),
      .R   (R),
      .bus (bus)
   );

   always #5 C = ~C;

   typedef struct packed {
      logic t;
      logic i;
   } sym_t;

   typedef struct packed {
      logic [NREQ-1:0] ack;
      logic [NREQ-1:0] gnt;
      logic            busy;
      logic            tx_t;
      logic            tx_i;
   } exp_t;

   typedef struct packed {
      logic [NREQ-1:0]  ack;
      logic [WIDTH-1:0] word;
   } xfer_t;

   exp_t  cyc_q[$];
   xfer_t xfer_q[$];

   int n_vec = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   sym_t frame_seq[$];
   sym_t m_cur;
   bit   m_idle  = 1'b1;
   int   m_ptr   = 0;
   int   m_owner = -1;

   task automatic model_step();
      exp_t  e;
      xfer_t x;
      int    win;
      logic [WIDTH-1:0] w;
      e = '0;
      if (R) begin
         frame_seq.delete();
         m_idle  = 1'b1;
         m_ptr   = 0;
         m_owner = -1;
      end else if (!m_idle) begin
         if (bus.HIZ && m_cur.t == 1'b0) begin
            frame_seq.delete();
            for (int g = 0; g < GUARD; g++) frame_seq.push_back(sym_t'(2'b10));
         end
         if (frame_seq.size() == 0) begin
            m_idle  = 1'b1;
            m_owner = -1;
         end else begin
            m_cur = frame_seq.pop_front();
         end
      end else if (!bus.HIZ && bus.REQ != '0) begin
         win = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && bus.REQ[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
         end
         m_ptr   = (win + 1) % NREQ;
         m_owner = win;
         w       = bus.DIN[win*WIDTH +: WIDTH];
         frame_seq.push_back(sym_t'(2'b01));
         for (int n = 0; n < WIDTH; n++) frame_seq.push_back(sym_t'({1'b0, w[n]}));
         for (int g = 0; g < GUARD; g++) frame_seq.push_back(sym_t'(2'b10));
         m_cur  = frame_seq.pop_front();
         m_idle = 1'b0;
         e.ack[win] = 1'b1;
         x.ack  = e.ack;
         x.word = w;
         xfer_q.push_back(x);
      end
      if (!m_idle) begin
         e.gnt[m_owner] = 1'b1;
         e.busy = 1'b1;
         e.tx_t = m_cur.t;
         e.tx_i = m_cur.i;
      end else begin
         e.tx_t = 1'b1;
         e.tx_i = 1'b0;
      end
      cyc_q.push_back(e);
   endtask

   initial begin
      forever begin
         @(posedge C);
         #1;
         model_step();
      end
   end

   // ---------------- monitor ----------------
   int               cyc = 0;
   bit               col_active = 1'b0;
   int               col_n = 0;
   logic [WIDTH-1:0] col_word;
   logic [WIDTH-1:0] col_exp;

   initial begin
      exp_t  e;
      exp_t  got;
      xfer_t x;
      forever begin
         @(negedge C);
         cyc++;
         got = {bus.ACK, bus.GNT, bus.BUSY, bus.TX_T, bus.TX_I};
         n_vec++;
         if (cyc_q.size() == 0) begin
            n_bad++;
            $display("FAIL underflow cycle %0d: got outputs %b, no expectation queued", cyc, got);
         end else begin
            e = cyc_q.pop_front();
            if (got !== e) begin
               n_bad++;
               $display("FAIL cycle %0d: ack=%b gnt=%b busy=%b tx_t=%b tx_i=%b, expected ack=%b gnt=%b busy=%b tx_t=%b tx_i=%b",
                        cyc, got.ack, got.gnt, got.busy, got.tx_t, got.tx_i,
                        e.ack, e.gnt, e.busy, e.tx_t, e.tx_i);
            end
         end
         // Reassemble the serialized word after each ACK and check it.
         if (col_active) begin
            if (bus.TX_T !== 1'b0) begin
               col_active = 1'b0;
            end else begin
               col_word[col_n] = bus.TX_I;
               col_n++;
               if (col_n == WIDTH) begin
                  col_active = 1'b0;
                  n_vec++;
                  if (col_word !== col_exp) begin
                     n_bad++;
                     $display("FAIL word cycle %0d: serialized %h, expected %h", cyc, col_word, col_exp);
                  end
               end
            end
         end
         if (bus.ACK !== '0) begin
            n_vec++;
            if (xfer_q.size() == 0) begin
               n_bad++;
               $display("FAIL ack cycle %0d: got ack %b, none expected", cyc, bus.ACK);
            end else begin
               x = xfer_q.pop_front();
               if (bus.ACK !== x.ack) begin
                  n_bad++;
                  $display("FAIL ack cycle %0d: got ack %b, expected %b", cyc, bus.ACK, x.ack);
               end
               col_active = 1'b1;
               col_n      = 0;
               col_exp    = x.word;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [NREQ-1:0] req, input logic hiz, input logic rst,
                       input int n, input bit a5 = 1'b0);
      for (int c = 0; c < n; c++) begin
         bus.REQ = req;
         bus.HIZ = hiz;
         R       = rst;
         for (int i = 0; i < NREQ; i++) bus.DIN[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         if (a5) bus.DIN[WIDTH-1:0] = 8'hA5;
         @(negedge C);
      end
   endtask

   initial begin
      logic [NREQ-1:0] rq;
      logic            hz;
      logic            rs;
      // reset state
      step('0, 1'b0, 1'b1, 3);
      // single frame of 0xA5 from requester 0
      step(4'b0001, 1'b0, 1'b0, 1, 1'b1);
      step('0, 1'b0, 1'b0, 14);
      // all requesting: rotation 0,1,2,3,0 with DIN churning mid-frame
      step(4'b1111, 1'b0, 1'b0, 60);
      step('0, 1'b0, 1'b0, 12);
      // two requesters alternate
      step(4'b0101, 1'b0, 1'b0, 40);
      step('0, 1'b0, 1'b0, 12);
      // HIZ during SHIFT, with requests pending while disabled
      step(4'b0001, 1'b0, 1'b0, 1);
      step('0, 1'b0, 1'b0, 4);
      step(4'b1111, 1'b1, 1'b0, 10);
      step('0, 1'b0, 1'b0, 3);
      // reset mid-frame with requests present, then requester 1
      step(4'b0001, 1'b0, 1'b0, 1);
      step('0, 1'b0, 1'b0, 5);
      step(4'b1111, 1'b0, 1'b1, 1);
      step(4'b0010, 1'b0, 1'b0, 1);
      step('0, 1'b0, 1'b0, 14);
      // one-cycle request while busy is dropped
      step(4'b0001, 1'b0, 1'b0, 1);
      step('0, 1'b0, 1'b0, 3);
      step(4'b0100, 1'b0, 1'b0, 1);
      step('0, 1'b0, 1'b0, 14);
      // random traffic with occasional HIZ and reset
      rq = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) rq = NREQ'($urandom);
         hz = ($urandom_range(99) < 3);
         rs = ($urandom_range(199) == 0);
         step(rq, hz, rs, 1);
      end
      step('0, 1'b0, 1'b0, 20);
      #2;
      n_vec++;
      if (xfer_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d captured words never acknowledged, expected 0", xfer_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
